// File: rtl/dcm_lock_monitor.sv
// Frequency-lock monitor: counts clk2x cycles across WINDOW rising edges of an
// asynchronous monitored clock and declares lock after LOCK_COUNT good windows.
`timescale 1ns/1ps
module dcm_lock_monitor #(
    parameter int CNT_W      = 16,
    parameter int WINDOW     = 8,
    parameter int EXPECTED   = 16,
    parameter int TOLERANCE  = 1,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk2x,
    input  logic             resetb,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic             clr_status,
    output logic             locked,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic [7:0]       status
);
    localparam int EW = $clog2(WINDOW + 1);
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [EW-1:0]    LAST_EDGE = EW'(WINDOW - 1);
    localparam logic [GW-1:0]    GAP_MAX   = GW'(TIMEOUT);
    localparam logic [LW-1:0]    LOCK_MAX  = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       sync_reg;
    logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
    logic [EW-1:0]    edge_cnt_reg, edge_cnt_next;
    logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
    logic [LW-1:0]    good_cnt_reg, good_cnt_next;
    logic             locked_reg, locked_next;
    logic             meas_valid_reg, meas_valid_next;
    logic [CNT_W-1:0] meas_count_reg, meas_count_next;
    logic [3:0]       status_reg, status_next;
    logic [3:0]       set_bits;
    logic             timeout;

    logic                    mon_edge;
    logic [CNT_W-1:0]        cycle_inc;
    logic [LW-1:0]           good_inc;
    logic signed [CNT_W:0]   diff, abs_diff;
    logic                    in_tol, saturated;

    assign mon_edge  = sync_reg[1] & ~sync_reg[2];
    assign cycle_inc = (cycle_cnt_reg == CNT_MAX) ? CNT_MAX : cycle_cnt_reg + 1'b1;
    assign good_inc  = (good_cnt_reg == LOCK_MAX) ? LOCK_MAX : good_cnt_reg + 1'b1;
    // One extra bit keeps the subtraction from wrapping for short windows.
    assign diff      = $signed({1'b0, cycle_cnt_reg}) - $signed((CNT_W + 1)'(EXPECTED));
    assign abs_diff  = diff[CNT_W] ? -diff : diff;
    assign in_tol    = abs_diff <= $signed((CNT_W + 1)'(TOLERANCE));
    assign saturated = (cycle_cnt_reg == CNT_MAX);

    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            sync_reg       <= '0;
            state_reg      <= IDLE;
            cycle_cnt_reg  <= '0;
            edge_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            good_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
            meas_valid_reg <= 1'b0;
            meas_count_reg <= '0;
            status_reg     <= '0;
        end else begin
            sync_reg       <= {sync_reg[1:0], mon_clk};
            state_reg      <= state_next;
            cycle_cnt_reg  <= cycle_cnt_next;
            edge_cnt_reg   <= edge_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            good_cnt_reg   <= good_cnt_next;
            locked_reg     <= locked_next;
            meas_valid_reg <= meas_valid_next;
            meas_count_reg <= meas_count_next;
            status_reg     <= status_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cycle_cnt_next  = cycle_cnt_reg;
        edge_cnt_next   = edge_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        good_cnt_next   = good_cnt_reg;
        locked_next     = (good_cnt_reg == LOCK_MAX);
        meas_valid_next = 1'b0;
        meas_count_next = meas_count_reg;
        set_bits        = 4'b0;
        timeout         = 1'b0;

        if (!enable) begin
            state_next     = IDLE;
            cycle_cnt_next = '0;
            edge_cnt_next  = '0;
            gap_cnt_next   = '0;
            good_cnt_next  = '0;
            locked_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: state_next = ARM;
                ARM: begin
                    if (mon_edge) begin
                        // cycle_cnt restarts at 1 so it always equals t - t_open.
                        state_next     = MEASURE;
                        cycle_cnt_next = CNT_W'(1);
                        edge_cnt_next  = '0;
                        gap_cnt_next   = '0;
                    end else if (gap_cnt_reg == GAP_MAX) begin
                        timeout = 1'b1;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 1'b1;
                    end
                end
                MEASURE: begin
                    if (mon_edge) begin
                        gap_cnt_next = '0;
                        if (edge_cnt_reg == LAST_EDGE) begin
                            meas_valid_next = 1'b1;
                            meas_count_next = cycle_cnt_reg;
                            edge_cnt_next   = '0;
                            cycle_cnt_next  = CNT_W'(1);
                            if (in_tol && !saturated) begin
                                good_cnt_next = good_inc;
                            end else begin
                                good_cnt_next = '0;
                                locked_next   = 1'b0;
                                set_bits[1]   = 1'b1;
                                set_bits[2]   = locked_reg;
                                set_bits[3]   = saturated;
                            end
                        end else begin
                            edge_cnt_next  = edge_cnt_reg + 1'b1;
                            cycle_cnt_next = cycle_inc;
                        end
                    end else if (gap_cnt_reg == GAP_MAX) begin
                        timeout = 1'b1;
                    end else begin
                        gap_cnt_next   = gap_cnt_reg + 1'b1;
                        cycle_cnt_next = cycle_inc;
                    end
                end
                default: state_next = IDLE;
            endcase

            if (timeout) begin
                state_next     = ARM;
                cycle_cnt_next = '0;
                edge_cnt_next  = '0;
                gap_cnt_next   = '0;
                good_cnt_next  = '0;
                locked_next    = 1'b0;
                set_bits[0]    = 1'b1;
                set_bits[2]    = locked_reg;
            end
        end

        status_next = (status_reg & ~{4{clr_status}}) | set_bits;
    end

    assign locked     = locked_reg;
    assign meas_valid = meas_valid_reg;
    assign meas_count = meas_count_reg;
    assign status     = {4'b0000, status_reg};
endmodule

// File: tb/tb_dcm_lock_monitor.sv
// Directed bench for dcm_lock_monitor: mon_clk is generated in whole clk2x
// periods so every measurement window length is known exactly.
`timescale 1ns/1ps
module tb_dcm_lock_monitor;
    logic        clk2x = 1'b0;
    logic        resetb = 1'b0;
    logic        mon_clk = 1'b0;
    logic        enable = 1'b0;
    logic        clr_status = 1'b0;
    logic        locked;
    logic        meas_valid;
    logic [15:0] meas_count;
    logic [7:0]  status;

    int checks = 0;
    int failures = 0;

    int mon_period = 2;
    int cur_per = 2;
    int phase = 0;
    bit mon_run = 1'b0;
    int per_q[$];

    dcm_lock_monitor dut (
        .clk2x(clk2x), .resetb(resetb), .mon_clk(mon_clk), .enable(enable),
        .clr_status(clr_status), .locked(locked), .meas_valid(meas_valid),
        .meas_count(meas_count), .status(status)
    );

    always #5 clk2x = ~clk2x;

    // One rising edge of mon_clk every cur_per clk2x cycles; queued periods override once.
    always @(negedge clk2x) begin
        if (!mon_run) begin
            mon_clk = 1'b0;
            phase   = 0;
            cur_per = mon_period;
        end else begin
            mon_clk = (phase == 0);
            phase++;
            if (phase >= cur_per) begin
                phase   = 0;
                cur_per = (per_q.size() > 0) ? per_q.pop_front() : mon_period;
            end
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk2x);
            if (meas_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_valid: meas_valid not seen within 400 cycles");
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk2x); clr_status = 1'b1;
        @(negedge clk2x); clr_status = 1'b0;
    endtask

    task automatic get_locked(input bit clear);
        bit ok;
        bit got = 1'b0;
        mon_period = 2;
        for (int k = 0; k < 10 && !got; k++) begin
            wait_valid(ok);
            @(negedge clk2x);
            got = locked;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL get_locked: locked=%0b required 1 within 10 windows", locked);
        end
        if (clear) pulse_clr();
    endtask

    task automatic test_reset();
        resetb = 1'b0; enable = 1'b0; mon_run = 1'b0;
        repeat (3) @(negedge clk2x);
        checks++;
        if ({locked, meas_valid, meas_count, status} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: locked=%0b valid=%0b count=%0d status=%h required all 0",
                     locked, meas_valid, meas_count, status);
        end
        resetb = 1'b1;
        @(negedge clk2x);
    endtask

    task automatic test_lock();
        bit ok;
        mon_period = 2; enable = 1'b1; mon_run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_valid(ok);
            checks++;
            if (meas_count !== 16'd16 || status !== 8'h00 || locked !== 1'b0) begin
                failures++;
                $display("FAIL lock_window%0d: count=%0d status=%h locked=%0b required 16/00/0",
                         k, meas_count, status, locked);
            end
        end
        @(negedge clk2x);
        checks++;
        if (locked !== 1'b1 || meas_valid !== 1'b0) begin
            failures++;
            $display("FAIL lock_rise: locked=%0b valid=%0b required 1/0", locked, meas_valid);
        end
        $display("test_lock: locked=%0b meas_count=%0d", locked, meas_count);
    endtask

    task automatic test_slow();
        bit ok;
        mon_period = 3;
        repeat (3) wait_valid(ok);
        checks++;
        if (meas_count !== 16'd24 || locked !== 1'b0) begin
            failures++;
            $display("FAIL slow_count: count=%0d locked=%0b required 24/0", meas_count, locked);
        end
        pulse_clr();
        checks++;
        if (status !== 8'h00) begin
            failures++;
            $display("FAIL slow_clr: status=%h required 00", status);
        end
        wait_valid(ok);
        checks++;
        if (status !== 8'h02 || meas_count !== 16'd24 || locked !== 1'b0) begin
            failures++;
            $display("FAIL slow_reflag: status=%h count=%0d locked=%0b required 02/24/0",
                     status, meas_count, locked);
        end
        $display("test_slow: status=%h meas_count=%0d", status, meas_count);
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen = 1'b0;
        get_locked(1'b1);
        mon_run = 1'b0;
        repeat (40) @(negedge clk2x);
        checks++;
        if (status[0] !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: status=%h locked=%0b required 00/1", status, locked);
        end
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk2x);
            seen = status[0];
        end
        checks++;
        if (!seen || locked !== 1'b0 || status !== 8'h05) begin
            failures++;
            $display("FAIL timeout_flag: status=%h locked=%0b required 05/0", status, locked);
        end
        mon_run = 1'b1;
        repeat (2) wait_valid(ok);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL timeout_relock_early: locked=%0b required 0", locked);
        end
        wait_valid(ok);
        @(negedge clk2x);
        checks++;
        if (locked !== 1'b1 || meas_count !== 16'd16) begin
            failures++;
            $display("FAIL timeout_relock: locked=%0b count=%0d required 1/16", locked, meas_count);
        end
        $display("test_timeout: relocked=%0b status=%h", locked, status);
    endtask

    task automatic test_tolerance();
        bit ok;
        get_locked(1'b1);
        per_q.push_back(3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            if (meas_count !== 16'd16) break;
        end
        checks++;
        if (meas_count !== 16'd17 || locked !== 1'b1 || status !== 8'h00) begin
            failures++;
            $display("FAIL tol_17: count=%0d locked=%0b status=%h required 17/1/00",
                     meas_count, locked, status);
        end
        per_q.push_back(4);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            if (meas_count !== 16'd16) break;
        end
        checks++;
        if (meas_count !== 16'd18 || locked !== 1'b0 || status !== 8'h06) begin
            failures++;
            $display("FAIL tol_18: count=%0d locked=%0b status=%h required 18/0/06",
                     meas_count, locked, status);
        end
        wait_valid(ok);
        @(negedge clk2x);
        checks++;
        if (meas_count !== 16'd16 || locked !== 1'b0) begin
            failures++;
            $display("FAIL tol_restart: count=%0d locked=%0b required 16/0", meas_count, locked);
        end
        $display("test_tolerance: status=%h", status);
    endtask

    task automatic test_async_reset();
        bit ok;
        get_locked(1'b0);
        per_q.push_back(4);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            if (meas_count !== 16'd16) break;
        end
        get_locked(1'b0);
        repeat (5) @(negedge clk2x);
        #2 resetb = 1'b0;
        #1;
        checks++;
        if ({locked, meas_valid, meas_count, status} !== 26'd0) begin
            failures++;
            $display("FAIL async_reset: locked=%0b valid=%0b count=%0d status=%h required all 0",
                     locked, meas_valid, meas_count, status);
        end
        @(negedge clk2x);
        resetb = 1'b1;
        repeat (3) wait_valid(ok);
        checks++;
        if (locked !== 1'b0 || meas_count !== 16'd16 || status !== 8'h00) begin
            failures++;
            $display("FAIL async_relock_pre: locked=%0b count=%0d status=%h required 0/16/00",
                     locked, meas_count, status);
        end
        @(negedge clk2x);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL async_relock: locked=%0b required 1", locked);
        end
        $display("test_async_reset: locked=%0b", locked);
    endtask

    task automatic test_clr_collision();
        bit ok;
        bit stray = 1'b0;
        get_locked(1'b1);
        clr_status = 1'b1;
        per_q.push_back(4);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            if (meas_count !== 16'd16) break;
        end
        checks++;
        if (status !== 8'h06 || meas_count !== 16'd18) begin
            failures++;
            $display("FAIL clr_collision: status=%h count=%0d required 06/18", status, meas_count);
        end
        clr_status = 1'b0;
        @(negedge clk2x);
        checks++;
        if (status !== 8'h06) begin
            failures++;
            $display("FAIL clr_collision_hold: status=%h required 06", status);
        end
        get_locked(1'b0);
        enable = 1'b0;
        @(negedge clk2x);
        checks++;
        if (locked !== 1'b0 || status !== 8'h06 || meas_count !== 16'd16) begin
            failures++;
            $display("FAIL disable: locked=%0b status=%h count=%0d required 0/06/16",
                     locked, status, meas_count);
        end
        repeat (40) begin
            @(negedge clk2x);
            if (meas_valid || locked) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL disable_idle: meas_valid or locked seen while disabled");
        end
        $display("test_clr_collision: status=%h locked=%0b", status, locked);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slow();
        test_timeout();
        test_tolerance();
        test_async_reset();
        test_clr_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
